// File: rtl/z16_data_memory_ctrl.sv
// Z16 data memory controller: req/ready/rvalid handshake in front of on-chip RAM,
// programmable read latency (1..4) and per-byte write strobes.
// Optional address checking is enabled by defining Z16_DMEM_ERR_EN; without it
// sub-word address bits are ignored, the word index wraps and o_err stays 0.
module z16_data_memory_ctrl #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned RD_LATENCY = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_req,
    input  logic                 i_wen,
    input  logic [ADDR_W-1:0]    i_addr,
    input  logic [DATA_W/8-1:0]  i_be,
    input  logic [DATA_W-1:0]    i_data,
    output logic                 o_ready,
    output logic                 o_rvalid,
    output logic [DATA_W-1:0]    o_data,
    output logic                 o_err
);

    localparam int unsigned BE_W     = DATA_W / 8;
    localparam int unsigned ADDR_LSB = (BE_W > 1) ? $clog2(BE_W) : 0;
    localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
    localparam int unsigned CNT_W    = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              state, state_nx;
    logic [CNT_W-1:0]    cnt, cnt_nx;
    logic [DATA_W-1:0]   rd_buf, rd_buf_nx;
    logic                rd_err, rd_err_nx;
    logic                ready_nx, rvalid_nx, err_nx;
    logic [DATA_W-1:0]   data_nx;

    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH_LOG2-1:0] idx_c;
    logic                accept_c;
    logic                addr_err_c;

    assign idx_c    = i_addr[ADDR_LSB +: DEPTH_LOG2];
    assign accept_c = i_req & o_ready;

`ifdef Z16_DMEM_ERR_EN
    logic misalign_c;
    logic range_c;

    // Flag sub-word misalignment and word indices beyond the RAM depth
    assign misalign_c = (i_addr & ADDR_W'(BE_W - 1)) != '0;
    assign range_c    = (i_addr >> (ADDR_LSB + DEPTH_LOG2)) != '0;
    assign addr_err_c = misalign_c | range_c;
`else
    logic addr_unused;

    // Low and high address bits are intentionally don't-care in this build
    assign addr_unused = ^i_addr;
    assign addr_err_c  = 1'b0;
`endif

    // RAM write port: byte-strobed, contents survive reset
    always_ff @(posedge i_clk) begin
        if (accept_c && i_wen && !addr_err_c) begin
            for (int unsigned k = 0; k < BE_W; k++) begin
                if (i_be[k]) begin
                    mem[idx_c][8*k +: 8] <= i_data[8*k +: 8];
                end
            end
        end
    end

    // Next-state and next-output logic; RESP accepts new requests like IDLE
    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        rd_buf_nx = rd_buf;
        rd_err_nx = rd_err;
        ready_nx  = 1'b1;
        rvalid_nx = 1'b0;
        err_nx    = 1'b0;
        data_nx   = o_data;

        case (state)
            S_WAIT: begin
                cnt_nx = cnt - 1'b1;
                if (cnt == CNT_W'(1)) begin
                    state_nx  = S_RESP;
                    rvalid_nx = 1'b1;
                    data_nx   = rd_buf;
                    err_nx    = rd_err;
                end else begin
                    ready_nx = 1'b0;
                end
            end
            default: begin
                state_nx = S_IDLE;
                if (accept_c) begin
                    if (i_wen) begin
                        err_nx = addr_err_c;
                    end else begin
                        rd_buf_nx = addr_err_c ? '0 : mem[idx_c];
                        rd_err_nx = addr_err_c;
                        cnt_nx    = CNT_W'(RD_LATENCY - 1);
                        if (RD_LATENCY == 1) begin
                            state_nx  = S_RESP;
                            rvalid_nx = 1'b1;
                            data_nx   = rd_buf_nx;
                            err_nx    = addr_err_c;
                        end else begin
                            state_nx = S_WAIT;
                            ready_nx = 1'b0;
                        end
                    end
                end
            end
        endcase
    end

    // State and registered outputs; reset drops any pending read
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rd_buf   <= '0;
            rd_err   <= 1'b0;
            o_ready  <= 1'b1;
            o_rvalid <= 1'b0;
            o_data   <= '0;
            o_err    <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            rd_buf   <= rd_buf_nx;
            rd_err   <= rd_err_nx;
            o_ready  <= ready_nx;
            o_rvalid <= rvalid_nx;
            o_data   <= data_nx;
            o_err    <= err_nx;
        end
    end

endmodule
